// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives instruction memory and absorbs its
// one-cycle read latency. It hands {pc, instr} to decode through a skid buffer.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   imem_addr/imem_data  instruction memory address (registered) and read data
//   redirect_valid/pc    taken branch/jump target; flushes everything in flight
//   out_valid/ready      handshake towards decode
//   out_pc/out_instr     fetched word and its byte address
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        ifl_valid_q, ifl_valid_d;
  logic [31:0] ifl_pc_q, ifl_pc_d;
  logic        skid_valid_q, skid_valid_d;
  fetch_word_t skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  fetch_word_t out_q, out_d;

  logic        accept;
  logic        issue;
  fetch_word_t ifl_word;

  // Target alignment bits are dropped.
  logic unused_ok;
  assign unused_ok = &{1'b0, redirect_pc[1:0]};

  assign accept   = !out_valid_q || out_ready;
  assign ifl_word = '{pc: ifl_pc_q, instr: imem_data};

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    ifl_valid_d  = ifl_valid_q;
    ifl_pc_d     = ifl_pc_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    issue        = 1'b0;

    if (redirect_valid) begin
      fetch_pc_d   = {redirect_pc[31:2], 2'b00};
      ifl_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b0;
    end else begin
      if (accept) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          out_valid_d  = 1'b1;
          skid_valid_d = 1'b0;
        end else if (ifl_valid_q) begin
          out_d       = ifl_word;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (ifl_valid_q) begin
        // Word already requested lands in the skid; out holds.
        skid_d       = ifl_word;
        skid_valid_d = 1'b1;
      end

      // Only request a new word while the skid stays empty, so at
      // most two words are ever pending (out + skid).
      issue = !skid_valid_d;
      if (issue) begin
        ifl_valid_d = 1'b1;
        ifl_pc_d    = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q + 32'd4;
      end else begin
        ifl_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q   <= RESET_PC;
      ifl_valid_q  <= 1'b0;
      ifl_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      ifl_valid_q  <= ifl_valid_d;
      ifl_pc_q     <= ifl_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign out_instr = out_q.instr;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a registered-read memory model.
// Word at address a is a ^ 32'hA5A5_0000.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) imem_data <= imem_addr ^ KEY;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_pc"}, out_pc, pc);
    chk({tag, "_instr"}, out_instr, pc ^ KEY);
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;

    // 1: reset and first word
    step();
    step();
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("lat_valid0", {31'd0, out_valid}, 32'd0);
    step();
    chk_word("first", 32'h0);

    // 2: streaming
    step();
    chk_word("s4", 32'h4);
    step();
    chk_word("s8", 32'h8);

    // 3: stall with out_pc=8
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_word("stall", 32'h8);
      chk("stall_addr", imem_addr, 32'h10);
    end
    out_ready = 1'b1;
    step();
    chk_word("rel12", 32'hC);
    step();
    chk_word("rel16", 32'h10);
    step();
    chk_word("rel20", 32'h14);

    // 4: redirect while streaming
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0042;
    step();
    redirect_valid = 1'b0;
    chk("rd_addr", imem_addr, 32'h40);
    chk("rd_v0", {31'd0, out_valid}, 32'd0);
    step();
    chk("rd_v1", {31'd0, out_valid}, 32'd0);
    step();
    chk_word("rd40", 32'h40);
    step();
    chk_word("rd44", 32'h44);

    // 5: redirect while stalled with skid full
    out_ready = 1'b0;
    step();
    step();
    chk_word("st5", 32'h44);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    chk("rs_v0", {31'd0, out_valid}, 32'd0);
    chk("rs_addr", imem_addr, 32'h80);
    step();
    chk("rs_v1", {31'd0, out_valid}, 32'd0);
    step();
    chk_word("rs80", 32'h80);
    step();
    chk_word("rs84", 32'h84);

    // 6: PC wrap
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_addr0", imem_addr, 32'h0);
    step();
    chk_word("wrFC", 32'hFFFF_FFFC);
    step();
    chk_word("wr0", 32'h0);
    step();
    chk_word("wr4", 32'h4);

    // 7: reset + redirect during full stall
    out_ready = 1'b0;
    step();
    step();
    chk_word("st7", 32'h4);
    rst_n          = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    chk("r7_valid", {31'd0, out_valid}, 32'd0);
    chk("r7_addr", imem_addr, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("r7_lat", {31'd0, out_valid}, 32'd0);
    step();
    chk_word("r7_0", 32'h0);
    step();
    chk_word("r7_4", 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
